audio_post_chain: RTL and testbench
===================================

# audio_post_chain

Output stage of the song player's audio path: four signed channel samples in, one processed sample out. Channel 0 (bass) passes through an exponentially weighted moving average (EWMA) low-pass filter. It is then combined with channels 1–3 by a saturating two-input mixer tree. The mix passes through a flanger, a modulated short delay averaged with the dry signal. Every `sample_clk` edge processes one sample.

## Interface
Parameters:
- `DATA_BITS`, 12: signed sample width for all sample ports.
- `DELAY_BITS`, 8: flanger delay memory depth is 2^DELAY_BITS samples.
- `SWEEP_SHIFT`, 6: flanger delay changes by one step every 2^SWEEP_SHIFT samples.

Ports:
- `sample_clk`, in, 1: the only clock; one sample per rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `ch0`, in, DATA_BITS: signed bass channel; feeds the EWMA filter.
- `ch1`, `ch2`, `ch3`, in, DATA_BITS: signed channels, mixed unfiltered.
- `s_alpha`, in, 8: unsigned EWMA coefficient, 0..255.
- `flanger_en`, in, 1: 1 = flanger active, 0 = dry passthrough.
- `audio_out`, out, DATA_BITS: signed, registered result.
- `flanger_delay`, out, DELAY_BITS: current flanger tap delay in samples, exposed for verification.

## Operation
EWMA filter (state `y`, signed DATA_BITS):
- `diff = ch0 - y`, DATA_BITS+1 bits.
- `prod = diff * s_alpha`, signed, with s_alpha zero-extended.
- `y_next = y + (prod >>> 8)`, arithmetic shift (floors toward −inf).
- `y` never leaves the DATA_BITS range, so no saturation is needed. `s_alpha = 0` holds `y`.
- Filter output `f0 = y`, the registered value.

Mixer, combinational:
- `sat(a+b)` is the exact sum, clamped to [−2^(DATA_BITS−1), 2^(DATA_BITS−1)−1].
- `m0 = sat(f0 + ch1)`, `m1 = sat(ch2 + ch3)`, `mix = sat(m0 + m1)`.

Flanger, input `x = mix`:
- Delay memory: write pointer `wp` (DELAY_BITS bits) starts at 0 and increments every cycle, wrapping. Each cycle `x` is written at `wp`.
- Tap `t` is the flanger input from exactly `d` cycles earlier (`mem[wp − d]`, modulo depth).
- `t` is forced to 0 while `wcount < d`. `wcount` counts samples written since reset and saturates at 2^DELAY_BITS. Memory contents are never reset.
- Output: `flanger_en = 1` gives `(x + t) >>> 1`, computed in DATA_BITS+1 bits. `flanger_en = 0` gives `x`.

Delay sweep (LFO):
- `d` resets to 1, direction up. The prescaler resets to 0 and counts every cycle.
- When the prescaler rolls over from all-ones, `d` takes one step:
  - up and `d == 2^DELAY_BITS − 1`: direction becomes down, `d − 1`.
  - down and `d == 1`: direction becomes up, `d + 1`.
  - otherwise: `d ± 1`.
- `d` forms a triangle from 1 to 255 with a period of 2·254·2^SWEEP_SHIFT samples (defaults).
- The sweep runs regardless of `flanger_en`.
- `flanger_delay = d`.

## Timing
- `rst` asserted, any time: immediately clears `y`, `wp`, `wcount`, the prescaler, and `audio_out` to 0; sets `d = 1`, direction up. Mid-operation reset behaves identically.
- Latency: `ch1`–`ch3` reach `audio_out` after 1 edge. `ch0` takes 2 edges: the EWMA register, then the output register.
- `s_alpha` and `flanger_en` are sampled every edge and take effect on that edge. There is no handshake.
- Simultaneous prescaler rollover and sample write: the write and tap use the pre-update `d`; the new `d` applies from the next edge.

## Test plan
- Reset: hold `rst`, all inputs 0 → `audio_out = 0`, `flanger_delay = 1`. Release with zero inputs → `audio_out` stays 0.
- Mixer saturation (DATA_BITS=12, `flanger_en=0`, ch0=0): ch1=ch2=ch3=1500 → `audio_out = 2047` after 1 edge. All channels −2048 → −2048.
- EWMA step (`flanger_en=0`, `s_alpha=255`, others 0): ch0 0→1000 gives `y` = 996, 999, 999. `audio_out` shows each value one edge later. With `s_alpha=0`, `y` stays 0.
- Flanger impulse: reset, `flanger_en=1`, ch1=1000 for the first cycle only → `audio_out` = 500, 500, then 0.
- Sweep: `flanger_delay` = 1 through sample 63, 2 at sample 64, peaks at 255, returns to 1, then rises again.
- Async reset mid-sweep (d≈100, nonzero audio) → all state cleared without a clock edge; the impulse test then repeats exactly.

Source files
------------

// File: rtl/audio_post_chain.sv
// audio_post_chain: output stage of the song player's audio path.
//
// Channel 0 (bass) goes through an EWMA low-pass filter. The result is
// combined with channels 1-3 by a saturating two-input mixer tree. The mix
// then feeds a flanger: a triangle-swept short delay averaged with the dry
// signal. One sample is processed on every rising edge of sample_clk.
//
// Ports:
//   sample_clk    - only clock, one sample per rising edge
//   rst           - asynchronous active-high reset
//   ch0           - signed bass channel, filtered by the EWMA
//   ch1..ch3      - signed channels, mixed unfiltered
//   s_alpha       - unsigned EWMA coefficient (0 holds the filter state)
//   flanger_en    - 1 = flanged output, 0 = dry mix
//   audio_out     - signed registered result
//   flanger_delay - current flanger tap delay in samples
module audio_post_chain #(
  parameter int DATA_BITS   = 12,
  parameter int DELAY_BITS  = 8,
  parameter int SWEEP_SHIFT = 6
) (
  input  logic                  sample_clk,
  input  logic                  rst,
  input  logic [DATA_BITS-1:0]  ch0,
  input  logic [DATA_BITS-1:0]  ch1,
  input  logic [DATA_BITS-1:0]  ch2,
  input  logic [DATA_BITS-1:0]  ch3,
  input  logic [7:0]            s_alpha,
  input  logic                  flanger_en,
  output logic [DATA_BITS-1:0]  audio_out,
  output logic [DELAY_BITS-1:0] flanger_delay
);

  localparam int DEPTH = 1 << DELAY_BITS;
  localparam logic [DELAY_BITS-1:0] D_MIN   = DELAY_BITS'(1);
  localparam logic [DELAY_BITS-1:0] D_MAX   = {DELAY_BITS{1'b1}};
  localparam logic [DELAY_BITS:0]   WC_FULL = {1'b1, {DELAY_BITS{1'b0}}};

  // Exact sum in one extra bit, clamped to the sample range on overflow.
  function automatic logic signed [DATA_BITS-1:0] sat_add(
    input logic signed [DATA_BITS-1:0] a,
    input logic signed [DATA_BITS-1:0] b
  );
    logic signed [DATA_BITS:0] s;
    s = {a[DATA_BITS-1], a} + {b[DATA_BITS-1], b};
    if (s[DATA_BITS] != s[DATA_BITS-1])
      return {s[DATA_BITS], {(DATA_BITS-1){~s[DATA_BITS]}}};
    return s[DATA_BITS-1:0];
  endfunction

  // (a + b) >>> 1 in one extra bit; the halved value always fits.
  function automatic logic signed [DATA_BITS-1:0] half_sum(
    input logic signed [DATA_BITS-1:0] a,
    input logic signed [DATA_BITS-1:0] b
  );
    logic signed [DATA_BITS:0] s;
    s = {a[DATA_BITS-1], a} + {b[DATA_BITS-1], b};
    return s[DATA_BITS:1];
  endfunction

  logic signed [DATA_BITS-1:0] y_p0;
  logic signed [DATA_BITS-1:0] y_next;
  logic signed [DATA_BITS:0]   ewma_diff;
  logic signed [DATA_BITS+9:0] ewma_prod;

  logic signed [DATA_BITS-1:0] m0;
  logic signed [DATA_BITS-1:0] m1;
  logic signed [DATA_BITS-1:0] mix_p0;
  logic signed [DATA_BITS-1:0] tap_p0;
  logic signed [DATA_BITS-1:0] flange_p0;
  logic signed [DATA_BITS-1:0] audio_out_p1;

  logic [DATA_BITS-1:0]   dly_mem [DEPTH];
  logic [DELAY_BITS-1:0]  wp;
  logic [DELAY_BITS-1:0]  rd_addr;
  logic [DELAY_BITS-1:0]  d;
  logic                   d_up;
  logic [DELAY_BITS:0]    wcount;
  logic [SWEEP_SHIFT-1:0] presc;

  // ---- stage p0: EWMA state update ----
  // The floored step keeps y between its old value and ch0, so y_next never
  // leaves the sample range and the truncation to DATA_BITS is exact.
  always_comb begin
    ewma_diff = {ch0[DATA_BITS-1], ch0} - {y_p0[DATA_BITS-1], y_p0};
    ewma_prod = ewma_diff * $signed({1'b0, s_alpha});
    y_next    = y_p0 + ewma_prod[DATA_BITS+7:8];
  end

  always_ff @(posedge sample_clk or posedge rst) begin
    if (rst) y_p0 <= '0;
    else     y_p0 <= y_next;
  end

  // ---- stage p0: mixer tree and flanger (combinational) ----
  always_comb begin
    m0      = sat_add(y_p0, ch1);
    m1      = sat_add(ch2, ch3);
    mix_p0  = sat_add(m0, m1);
    rd_addr = wp - d;
    // Slots not yet written since reset read as silence.
    tap_p0    = (wcount < {1'b0, d}) ? '0 : dly_mem[rd_addr];
    flange_p0 = flanger_en ? half_sum(mix_p0, tap_p0) : mix_p0;
  end

  // Delay line contents are deliberately left unreset; wcount masks stale data.
  always_ff @(posedge sample_clk) begin
    dly_mem[wp] <= mix_p0;
  end

  // Write pointer, fill counter and triangle sweep of the tap delay.
  // The step happens on prescaler rollover, so this edge's write and tap
  // still use the old d.
  always_ff @(posedge sample_clk or posedge rst) begin
    if (rst) begin
      wp     <= '0;
      wcount <= '0;
      presc  <= '0;
      d      <= D_MIN;
      d_up   <= 1'b1;
    end else begin
      wp    <= wp + D_MIN;
      presc <= presc + SWEEP_SHIFT'(1);
      if (wcount != WC_FULL) wcount <= wcount + (DELAY_BITS+1)'(1);
      if (&presc) begin
        if (d_up) begin
          if (d == D_MAX) begin
            d_up <= 1'b0;
            d    <= d - D_MIN;
          end else begin
            d <= d + D_MIN;
          end
        end else begin
          if (d == D_MIN) begin
            d_up <= 1'b1;
            d    <= d + D_MIN;
          end else begin
            d <= d - D_MIN;
          end
        end
      end
    end
  end

  // ---- stage p1: output register ----
  always_ff @(posedge sample_clk or posedge rst) begin
    if (rst) audio_out_p1 <= '0;
    else     audio_out_p1 <= flange_p0;
  end

  assign audio_out     = audio_out_p1;
  assign flanger_delay = d;

endmodule

// File: tb/tb_audio_post_chain.sv
// Self-checking bench for audio_post_chain with a reference-model scoreboard.
module tb_audio_post_chain;

  localparam int DW = 12;
  localparam int LW = 8;

  logic          sample_clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] ch0 = '0, ch1 = '0, ch2 = '0, ch3 = '0;
  logic [7:0]    s_alpha = '0;
  logic          flanger_en = 1'b0;
  logic [DW-1:0] audio_out;
  logic [LW-1:0] flanger_delay;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state
  int y_m = 0;
  int n_m = 0;
  int hist [256];
  int aq[$];
  int dq[$];
  int exp_a, exp_d;

  audio_post_chain #(.DATA_BITS(DW), .DELAY_BITS(LW), .SWEEP_SHIFT(6)) dut (
    .sample_clk(sample_clk), .rst(rst),
    .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
    .s_alpha(s_alpha), .flanger_en(flanger_en),
    .audio_out(audio_out), .flanger_delay(flanger_delay)
  );

  always #5 sample_clk = ~sample_clk;

  function automatic int sat12(int v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  // Delay in effect while sample n (0-based since reset) is processed.
  function automatic int model_d(int n);
    int p;
    p = (n / 64) % 508;
    return (p <= 254) ? 1 + p : 509 - p;
  endfunction

  function automatic int rnd_sample();
    return int'($urandom_range(4095)) - 2048;
  endfunction

  // Computes the expected output for one sample, queues it, drives the DUT
  // and advances one edge.
  task automatic drive_sample(input int c0, c1, c2, c3, alpha, en);
    int d, x, t, o;
    d = model_d(n_m);
    x = sat12(sat12(y_m + c1) + sat12(c2 + c3));
    t = (n_m < d) ? 0 : hist[(n_m - d) % 256];
    o = (en != 0) ? ((x + t) >>> 1) : x;
    hist[n_m % 256] = x;
    y_m = y_m + (((c0 - y_m) * alpha) >>> 8);
    n_m++;
    aq.push_back(o);
    dq.push_back(model_d(n_m));
    ch0 = DW'(c0); ch1 = DW'(c1); ch2 = DW'(c2); ch3 = DW'(c3);
    s_alpha = 8'(alpha); flanger_en = (en != 0);
    @(posedge sample_clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    ch0 = '0; ch1 = '0; ch2 = '0; ch3 = '0; s_alpha = '0; flanger_en = 1'b0;
    @(posedge sample_clk);
    @(posedge sample_clk);
    @(negedge sample_clk);
    rst = 1'b0;
    y_m = 0; n_m = 0;
    aq.delete(); dq.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge sample_clk);
    @(posedge sample_clk);
    #1;
    n_checks++;
    if (audio_out !== '0) begin
      n_fail++; $display("FAIL reset_out got %0d want 0", $signed(audio_out));
    end
    n_checks++;
    if (flanger_delay !== 8'd1) begin
      n_fail++; $display("FAIL reset_delay got %0d want 1", flanger_delay);
    end
    @(negedge sample_clk);
    rst = 1'b0;
    y_m = 0; n_m = 0;
    aq.delete(); dq.delete();
    for (int i = 0; i < 4; i++) begin
      drive_sample(0, 0, 0, 0, 0, 0);
      exp_a = aq.pop_front(); exp_d = dq.pop_front();
      n_checks++;
      if (audio_out !== DW'(exp_a) || audio_out !== '0) begin
        n_fail++; $display("FAIL reset_idle[%0d] got %0d want 0", i, $signed(audio_out));
      end
    end
  endtask

  task automatic test_mixer_sat();
    int stim [3][4] = '{'{0, 1500, 1500, 1500}, '{-2048, -2048, -2048, -2048}, '{0, 100, 200, -50}};
    int want [3] = '{2047, -2048, 250};
    for (int i = 0; i < 3; i++) begin
      drive_sample(stim[i][0], stim[i][1], stim[i][2], stim[i][3], 0, 0);
      exp_a = aq.pop_front(); exp_d = dq.pop_front();
      n_checks++;
      if (audio_out !== DW'(exp_a) || audio_out !== DW'(want[i])) begin
        n_fail++;
        $display("FAIL mixer_sat[%0d] got %0d want %0d", i, $signed(audio_out), want[i]);
      end
    end
  endtask

  task automatic test_ewma();
    int want [5] = '{0, 996, 999, 999, 999};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive_sample(1000, 0, 0, 0, 255, 0);
      exp_a = aq.pop_front(); exp_d = dq.pop_front();
      n_checks++;
      if (audio_out !== DW'(exp_a) || audio_out !== DW'(want[i])) begin
        n_fail++;
        $display("FAIL ewma_step[%0d] got %0d want %0d", i, $signed(audio_out), want[i]);
      end
    end
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive_sample(1000, 0, 0, 0, 0, 0);
      exp_a = aq.pop_front(); exp_d = dq.pop_front();
      n_checks++;
      if (audio_out !== DW'(exp_a) || audio_out !== '0) begin
        n_fail++; $display("FAIL ewma_hold[%0d] got %0d want 0", i, $signed(audio_out));
      end
    end
  endtask

  task automatic run_impulse(input string tag);
    int want [4] = '{500, 500, 0, 0};
    for (int i = 0; i < 4; i++) begin
      drive_sample(0, (i == 0) ? 1000 : 0, 0, 0, 0, 1);
      exp_a = aq.pop_front(); exp_d = dq.pop_front();
      n_checks++;
      if (audio_out !== DW'(exp_a) || audio_out !== DW'(want[i])) begin
        n_fail++;
        $display("FAIL %s[%0d] got %0d want %0d", tag, i, $signed(audio_out), want[i]);
      end
    end
  endtask

  task automatic test_flanger_impulse();
    apply_reset();
    run_impulse("impulse");
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      drive_sample(rnd_sample(), rnd_sample(), rnd_sample(), rnd_sample(),
                   int'($urandom_range(255)), int'($urandom_range(1)));
      exp_a = aq.pop_front(); exp_d = dq.pop_front();
      n_checks++;
      if (audio_out !== DW'(exp_a)) begin
        n_fail++; $display("FAIL b2b_out[%0d] got %0d want %0d", i, $signed(audio_out), exp_a);
      end
      n_checks++;
      if (flanger_delay !== LW'(exp_d)) begin
        n_fail++; $display("FAIL b2b_delay[%0d] got %0d want %0d", i, flanger_delay, exp_d);
      end
    end
  endtask

  task automatic test_sweep();
    int max_d = 0;
    int k, want;
    apply_reset();
    for (int i = 0; i < 509 * 64 + 2; i++) begin
      drive_sample(rnd_sample(), rnd_sample(), rnd_sample(), rnd_sample(),
                   int'($urandom_range(255)), 1);
      k = i + 1;
      exp_a = aq.pop_front(); exp_d = dq.pop_front();
      n_checks++;
      if (audio_out !== DW'(exp_a)) begin
        n_fail++; $display("FAIL sweep_out[%0d] got %0d want %0d", k, $signed(audio_out), exp_a);
      end
      n_checks++;
      if (flanger_delay !== LW'(exp_d)) begin
        n_fail++; $display("FAIL sweep_delay[%0d] got %0d want %0d", k, flanger_delay, exp_d);
      end
      if (int'(flanger_delay) > max_d) max_d = int'(flanger_delay);
      want = -1;
      if (k == 63) want = 1;
      if (k == 64) want = 2;
      if (k == 254 * 64) want = 255;
      if (k == 255 * 64) want = 254;
      if (k == 508 * 64) want = 1;
      if (k == 509 * 64) want = 2;
      if (want >= 0) begin
        n_checks++;
        if (flanger_delay !== LW'(want)) begin
          n_fail++; $display("FAIL sweep_point[%0d] got %0d want %0d", k, flanger_delay, want);
        end
      end
    end
    n_checks++;
    if (max_d != 255) begin
      n_fail++; $display("FAIL sweep_peak got %0d want 255", max_d);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 100 * 64; i++) begin
      drive_sample(0, 500, 0, 0, 0, 1);
      exp_a = aq.pop_front(); exp_d = dq.pop_front();
    end
    n_checks++;
    if (audio_out !== DW'(exp_a) || audio_out !== DW'(500)) begin
      n_fail++; $display("FAIL pre_reset_out got %0d want 500", $signed(audio_out));
    end
    n_checks++;
    if (flanger_delay !== LW'(exp_d) || flanger_delay !== 8'd101) begin
      n_fail++; $display("FAIL pre_reset_delay got %0d want 101", flanger_delay);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (audio_out !== '0) begin
      n_fail++; $display("FAIL async_reset_out got %0d want 0", $signed(audio_out));
    end
    n_checks++;
    if (flanger_delay !== 8'd1) begin
      n_fail++; $display("FAIL async_reset_delay got %0d want 1", flanger_delay);
    end
    apply_reset();
    run_impulse("impulse_after_reset");
  endtask

  initial begin
    test_reset();
    test_mixer_sat();
    test_ewma();
    test_flanger_impulse();
    test_back_to_back();
    test_sweep();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
